// File: rtl/d_ff_pkg.sv
// Shared defaults for the d_ff storage element and its standalone clock source.
package d_ff_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 1;
  localparam int unsigned DEFAULT_HALF_PERIOD = 10;

  // Replicated WIDTH times to form the all-zeros reset pattern.
  localparam logic        RESET_ZERO_BIT      = 1'b0;

endpackage : d_ff_pkg

// File: rtl/d_ff.sv
// Positive-edge D register with synchronous active-low reset, load enable
// and a complementary output derived straight from the register.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int unsigned           WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{RESET_ZERO_BIT}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  // Reset wins over enable; with en low the register simply holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q <= RESET_VALUE;
    end else if (en) begin
      Q <= D;
    end
  end

  assign Q_n = ~Q;

endmodule : d_ff

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: directed scenarios on a 1-bit and an 8-bit
// instance, then a randomized run against a behavioural reference model.
module tb_d_ff;
  import d_ff_pkg::*;

  localparam logic [7:0] RV8 = 8'h5A;

  logic       clk;
  logic       rst1_n, en1;
  logic [0:0] d1, q1, qn1;
  logic       rst8_n, en8;
  logic [7:0] d8, q8, qn8;

  int checks   = 0;
  int failures = 0;

  clock_gen #(.HALF_PERIOD(10)) u_clk (.out(clk));

  d_ff #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .D(d1), .Q(q1), .Q_n(qn1)
  );

  d_ff #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .en(en8), .D(d8), .Q(q8), .Q_n(qn8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge only.
  task automatic step();
    @(negedge clk);
  endtask

  logic [7:0] exp8;
  logic       r_rst, r_en;
  logic [7:0] r_d;

  initial begin
    // Phase 1: 1-bit capture timeline, 8-bit instance held in reset.
    rst1_n = 1'b1; en1 = 1'b1; d1 = 1'b0;
    rst8_n = 1'b0; en8 = 1'b1; d8 = 8'hFF;
    for (int t = 20; t <= 220; t += 20) begin
      step();
      check("capture_q",  8'(q1),  (t < 90) ? 8'h00 : 8'h01);
      check("capture_qn", 8'(qn1), (t < 90) ? 8'h01 : 8'h00);
      if (t == 80) d1 = 1'b1;
    end
    check("reset_state8",    q8,  RV8);
    check("reset_state8_qn", qn8, ~RV8);

    // Phase 2: reset overrides en/D on the 1-bit instance.
    rst1_n = 1'b0; d1 = 1'b1; en1 = 1'b1;
    step(); check("rst_edge1_q", 8'(q1), 8'h00);
    step(); check("rst_edge2_q", 8'(q1), 8'h00);
    check("rst_edge2_qn", 8'(qn1), 8'h01);
    rst1_n = 1'b1;
    step(); check("rst_release_q", 8'(q1), 8'h01);

    // Phase 3: enable hold on the 8-bit instance.
    rst8_n = 1'b1; en8 = 1'b1; d8 = 8'hA5;
    step(); check("load_a5", q8, 8'hA5);
    en8 = 1'b0; d8 = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      step(); check("hold_a5", q8, 8'hA5);
    end
    en8 = 1'b1;
    step(); check("load_3c", q8, 8'h3C);

    // Phase 4: mid-run reset with en low.
    d8 = 8'hFF;
    step(); check("load_ff", q8, 8'hFF);
    rst8_n = 1'b0; en8 = 1'b0;
    step(); check("midrun_reset", q8, RV8);
    check("midrun_reset_qn", qn8, 8'hA5);
    rst8_n = 1'b1; en8 = 1'b1; d8 = 8'hC3;
    step(); check("resume_capture", q8, 8'hC3);

    // Phase 5: reset glitch between edges has no effect.
    en8 = 1'b0;
    #4 rst8_n = 1'b0; rst1_n = 1'b0;
    #2 rst8_n = 1'b1; rst1_n = 1'b1;
    step(); check("glitch_q8", q8, 8'hC3);
    check("glitch_q1", 8'(q1), 8'h01);

    // Phase 6: randomized run against the reference model.
    exp8 = q8;
    for (int i = 0; i < 200; i++) begin
      r_rst = ($urandom_range(0, 15) != 0);
      r_en  = 1'($urandom_range(0, 1));
      r_d   = 8'($urandom);
      rst8_n = r_rst; en8 = r_en; d8 = r_d;
      step();
      if (!r_rst)    exp8 = RV8;
      else if (r_en) exp8 = r_d;
      check("rand_q",  q8,  exp8);
      check("rand_qn", qn8, ~exp8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_d_ff

// Free-running square wave for standalone simulation; starts low and first
// rises at HALF_PERIOD.
module clock_gen
  import d_ff_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  output logic out
);

  initial begin
    out = 1'b0;
    forever #(HALF_PERIOD) out = ~out;
  end

endmodule : clock_gen

// File: doc/d_ff.md
# d_ff

Parameterised positive-edge D-type register with a synchronous active-low reset, load enable and complementary output. It is the basic storage element for pipeline and state registers across the design library. A companion free-running clock source, `clock_gen`, drives it in standalone simulation.

## Interface
Parameters:
- `WIDTH`, 1: data width in bits, minimum 1.
- `RESET_VALUE`, all zeros: value loaded into `Q` on reset, `WIDTH` bits.
- `HALF_PERIOD`, 10: `clock_gen` only; time units per clock phase, minimum 1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  synchronous active-low reset, sampled only on rising `clk`.
- `en`  input  1  load enable; tie to 1 for a plain D flip-flop.
- `D`  input  `WIDTH`  data to capture.
- `Q`  output  `WIDTH`  registered data.
- `Q_n`  output  `WIDTH`  bitwise complement of `Q`.

`clock_gen` ports:
- `out`  output  1  free-running square wave; starts at 0; toggles every `HALF_PERIOD`.

## Operation
- Rising `clk` with `rst_n`=0: `Q` ← `RESET_VALUE`. Reset overrides `en` and `D`.
- Rising `clk` with `rst_n`=1 and `en`=1: `Q` ← `D`.
- Rising `clk` with `rst_n`=1 and `en`=0: `Q` holds its value.
- `Q_n` = ~`Q` at all times. It is combinational from the register, so it never carries separate state.
- No other state exists. There is no asynchronous path from `D`, `en` or `rst_n` to `Q`.
- Before the first qualifying edge, `Q` is X in simulation. Integrations must assert reset for at least one edge or load with `en`=1.
- X/Z on `D` with `en`=1 propagates to `Q` unchanged. The block does no masking.

## Timing
- Latency from `D` to `Q` is 1 clock: the value present at rising edge N is visible on `Q` after edge N and stays stable until edge N+1.
- Reset assert or deassert takes effect only at the next rising edge. A `rst_n` glitch between edges has no effect.
- Reset mid-operation: the edge that samples `rst_n`=0 loads `RESET_VALUE` regardless of `en`/`D`. The first edge with `rst_n`=1 resumes normal capture.
- `D` changing at the same time step as the rising edge: the pre-edge value is captured. Use nonblocking assignment semantics.
- `clock_gen` period is 2·`HALF_PERIOD` with 50 % duty. The first rising edge is at t=`HALF_PERIOD`.

## Structure
- Shared package `d_ff_pkg`: default `WIDTH`, default `HALF_PERIOD`, and a helper constant for the all-zeros reset pattern.
- Sub-module `clock_gen`: simulation-only and not synthesisable. It lives in its own file and is never instantiated inside `d_ff`.
- `d_ff` consists of one always block on `posedge clk` plus a continuous assignment for `Q_n`. A per-bit generate is not required.

## Test plan
- Reset: `rst_n`=0 for 2 edges with `D`=1 and `en`=1 → `Q`=`RESET_VALUE` (0), `Q_n`=1. Then release `rst_n`, and the next edge gives `Q`=1.
- Capture/toggle (WIDTH=1, `HALF_PERIOD`=10): `D`=0 from t=0 and `D`=1 at t=80 → `Q`=0 through the edge at t=70; `Q` becomes 1 after the edge at t=90 and stays 1 until the end at t=230.
- Enable hold: load 8'hA5, then `en`=0 with `D`=8'h3C for 3 edges → `Q` stays 8'hA5. Set `en`=1 → `Q`=8'h3C after the next edge.
- Mid-run reset (WIDTH=8, `RESET_VALUE`=8'h5A): `Q`=8'hFF, assert `rst_n`=0 for one edge with `en`=0 → `Q`=8'h5A.
- Between-edge reset pulse: pulse `rst_n` low for 2 time units away from the edges → `Q` is unchanged.
- `Q_n` check: for every sampled cycle, `Q_n` == ~`Q`. Random `D`/`en` runs for 200 cycles against a reference model.
